// File: rtl/axi_burst_dma.sv
// AXI4 master DMA: splits one read/write command into INCR bursts.
// Build option: AXI_DMA_4K_SPLIT_EN keeps bursts inside 4 KB pages.
module axi_burst_dma #(
  parameter int ID_WIDTH        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int LEN_WIDTH       = 24,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_cmptd,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int SZ = $clog2(DATA_WIDTH / 8);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] axaddr_q, axaddr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [7:0]            axlen_q, axlen_d;
  logic                  axvalid_q, axvalid_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic                  live_q;

  logic [7:0]    q_mem [2**PW];
  logic [PW-1:0] q_wp_q, q_rp_q;
  logic [OW-1:0] q_cnt_q;
  logic [7:0]    beat_q;
  logic          q_ne;

  logic                  accept, load, slot_free, all_issued;
  logic                  aw_hs, ar_hs, ax_hs, w_hs, b_hs, r_hs, dec;
  logic [LEN_WIDTH-1:0]  cmd_beats, base_rem, n_burst;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  unused_ids;

  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
  assign err       = err_q;
  // live_q holds cmd_ready low while reset is asserted
  assign cmd_ready = (state_q == S_IDLE) & init_cmptd & live_q;
  assign accept    = cmd_valid & cmd_ready;
  assign cmd_beats = cmd_len >> SZ;

  // On accept the first request is built straight from the command
  assign base_addr = accept ? cmd_addr : addr_q;
  assign base_rem  = accept ? cmd_beats : rem_q;

`ifdef AXI_DMA_4K_SPLIT_EN
  logic [12:0] to4k;
  assign to4k = (13'h1000 - {1'b0, base_addr[11:0]}) >> SZ;
`endif

  always_comb begin
    n_burst = base_rem;
    if (n_burst > LEN_WIDTH'(MAX_BURST)) n_burst = LEN_WIDTH'(MAX_BURST);
`ifdef AXI_DMA_4K_SPLIT_EN
    if (n_burst > LEN_WIDTH'(to4k)) n_burst = LEN_WIDTH'(to4k);
`endif
  end

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign ax_hs = aw_hs | ar_hs;
  assign w_hs  = m_axi_wvalid & m_axi_wready;
  assign b_hs  = m_axi_bvalid & m_axi_bready;
  assign r_hs  = m_axi_rvalid & m_axi_rready;
  assign dec   = write_q ? b_hs : (r_hs & m_axi_rlast);

  assign outst_d    = outst_q + OW'(ax_hs) - OW'(dec);
  assign slot_free  = ~axvalid_q | ax_hs;
  assign all_issued = (rem_q == '0) & slot_free;
  // Load the next request only if it will see a free outstanding slot
  assign load = accept ? (cmd_beats != '0)
              : (state_q == S_RUN) & (rem_q != '0) & slot_free &
                (outst_d < OW'(MAX_OUTSTANDING));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    axaddr_d  = axaddr_q;
    axlen_d   = axlen_q;
    axvalid_d = axvalid_q;
    write_d   = write_q;
    err_d     = err_q;
    if (accept) begin
      write_d = cmd_write;
      err_d   = 1'b0;
      addr_d  = cmd_addr;
      rem_d   = cmd_beats;
    end
    if (load) begin
      axaddr_d  = base_addr;
      axlen_d   = 8'(n_burst - LEN_WIDTH'(1));
      addr_d    = base_addr + (ADDR_WIDTH'(n_burst) << SZ);
      rem_d     = base_rem - n_burst;
      axvalid_d = 1'b1;
    end else if (ax_hs) begin
      axvalid_d = 1'b0;
    end
    if ((b_hs && m_axi_bresp != 2'b00) || (r_hs && m_axi_rresp != 2'b00))
      err_d = 1'b1;
    case (state_q)
      S_IDLE: if (accept) state_d = (cmd_beats == '0) ? S_DONE : S_RUN;
      S_RUN, S_DRAIN: begin
        if (all_issued && outst_d == '0) state_d = S_DONE;
        else if (all_issued)             state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      axaddr_q  <= '0;
      axlen_q   <= '0;
      axvalid_q <= 1'b0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      outst_q   <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      axaddr_q  <= axaddr_d;
      axlen_q   <= axlen_d;
      axvalid_q <= axvalid_d;
      write_q   <= write_d;
      err_q     <= err_d;
      outst_q   <= outst_d;
      live_q    <= 1'b1;
    end
  end

  // Burst-length queue: one entry per accepted AW, popped on wlast
  always_ff @(posedge clk) begin
    if (aw_hs) q_mem[q_wp_q] <= axlen_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_wp_q  <= '0;
      q_rp_q  <= '0;
      q_cnt_q <= '0;
      beat_q  <= '0;
    end else begin
      if (aw_hs) q_wp_q <= q_wp_q + 1'b1;
      if (w_hs && m_axi_wlast) q_rp_q <= q_rp_q + 1'b1;
      q_cnt_q <= q_cnt_q + OW'(aw_hs) - OW'(w_hs & m_axi_wlast);
      if (w_hs) beat_q <= m_axi_wlast ? 8'd0 : beat_q + 8'd1;
    end
  end

  assign q_ne = q_cnt_q != '0;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = axaddr_q;
  assign m_axi_awlen   = axlen_q;
  assign m_axi_awsize  = busy ? 3'(SZ) : 3'b0;
  assign m_axi_awburst = busy ? 2'b01 : 2'b00;
  assign m_axi_awvalid = axvalid_q & write_q;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = axaddr_q;
  assign m_axi_arlen   = axlen_q;
  assign m_axi_arsize  = busy ? 3'(SZ) : 3'b0;
  assign m_axi_arburst = busy ? 2'b01 : 2'b00;
  assign m_axi_arvalid = axvalid_q & ~write_q;

  assign m_axi_wdata  = wr_data;
  assign m_axi_wstrb  = '1;
  assign m_axi_wlast  = q_ne & (beat_q == q_mem[q_rp_q]);
  assign m_axi_wvalid = wr_valid & q_ne;
  assign wr_ready     = m_axi_wready & q_ne;

  assign m_axi_bready = busy;

  assign rd_data      = m_axi_rdata;
  assign rd_valid     = m_axi_rvalid & busy;
  assign m_axi_rready = rd_ready & busy;

endmodule

// File: doc/axi_burst_dma.md
# axi_burst_dma

Parametrised AXI4 master DMA engine between the datapath stream FIFOs and the MIG AXI slave port. It accepts one read or write command (start address, byte length) at a time and splits it into INCR bursts of up to MAX_BURST beats, with optional 4 KB-boundary splitting. It keeps up to MAX_OUTSTANDING bursts in flight, tracks write responses and read completions, and reports completion and a sticky error.

## Interface
- ID_WIDTH, 4: AXI ID width; all IDs are driven 0.
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 64: AXI data width; power of two, 32..512.
- LEN_WIDTH, 24: command byte-length width.
- MAX_BURST, 16: maximum beats per burst; power of two, 1..256.
- MAX_OUTSTANDING, 4: maximum bursts issued but not completed; power of two ≥1.
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- init_cmptd  in  1  memory calibration done; gates command acceptance only.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte start address, DATA_WIDTH/8-aligned.
- cmd_len  in  LEN_WIDTH  byte count, multiple of DATA_WIDTH/8.
- wr_data / wr_valid / wr_ready  in / in / out  DATA_WIDTH / 1 / 1  write-data stream in.
- rd_data / rd_valid / rd_ready  out / out / in  DATA_WIDTH / 1 / 1  read-data stream out.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  sticky: any BRESP/RRESP ≠ OKAY during the current command.
- m_axi_awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1  AW channel.
- m_axi_awready  in  1
- m_axi_wdata/wstrb/wlast/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1/1  W channel.
- m_axi_wready  in  1
- m_axi_bid/bresp/bvalid  in  ID_WIDTH/2/1; m_axi_bready  out  1.
- m_axi_arid/araddr/arlen/arsize/arburst/arvalid  out  same widths as AW; m_axi_arready  in  1.
- m_axi_rid/rdata/rresp/rlast/rvalid  in  ID_WIDTH/DATA_WIDTH/2/1/1; m_axi_rready  out  1.

## Operation
- Beat size B = DATA_WIDTH/8. Total beats = cmd_len >> log2(B). size = log2(B). burst = INCR (2'b01). wstrb = all ones.
- FSM: IDLE → RUN on command accept; RUN → DRAIN when all bursts are issued; DRAIN → DONE when outstanding = 0; DONE → IDLE after one cycle, with done = 1 in DONE.
- cmd_ready = (state == IDLE) & init_cmptd. On accept, err clears and the address and remaining-beat registers load.
- If cmd_len = 0, the FSM goes IDLE → DONE directly and issues no AXI traffic.
- Each burst has n = min(remaining, MAX_BURST, beats to next 4 KB boundary). len = n−1. The next address is addr + n·B, computed in full ADDR_WIDTH.
- An AW/AR request is presented only while outstanding < MAX_OUTSTANDING. The outstanding count increments on an AW/AR handshake. It decrements on a B handshake (write) or an R handshake with rlast (read). Simultaneous increment and decrement leave the count unchanged.
- Write data: each AW handshake pushes n into a burst-length queue of depth MAX_OUTSTANDING.
  - wvalid = wr_valid & queue non-empty; wr_ready = wready & queue non-empty; wdata = wr_data.
  - wlast is asserted on beat n of the head entry; the entry pops on the wlast handshake.
- bready = 1 while busy.
- Read data: rd_data = rdata, rd_valid = rvalid, rready = rd_ready while busy, else 0. Backpressure propagates directly.
- err sets on a B handshake with bresp ≠ 0 or an R handshake with rresp ≠ 0, and holds until the next accept.
- init_cmptd falling during RUN does not abort the command; it blocks only the next accept.

## Timing
- Reset values: awvalid/arvalid/wvalid/bready/rready/wr_ready/rd_valid = 0, busy = done = err = 0, cmd_ready = 0, addr/len/size/burst/id outputs = 0. Asynchronous assertion returns the FSM to IDLE and empties the queue.
- awvalid/arvalid are registered. The first request is asserted the cycle after accept. Address and len stay stable while valid & !ready.
- Back-to-back bursts: the next request is presented the cycle after a handshake if the outstanding limit allows, so valid may stay high continuously.
- W and R stream paths are combinational, with zero added latency.
- done pulses exactly 1 cycle after the cycle that drives outstanding to 0 with no beats remaining. cmd_ready rises the cycle after done.

## Configuration
- AXI_DMA_4K_SPLIT_EN defined: bursts never cross a 4 KB address boundary, per the min() above.
- Not defined: the 4 KB term is omitted and n = min(remaining, MAX_BURST). The caller guarantees aligned buffers.

## Test plan
- Write 256 bytes at 0x1000 (DATA_WIDTH 64, MAX_BURST 16) -> two AWs, 0x1000 with len 15 and 0x1080 with len 15. wlast on beats 16 and 32. Two B responses, then done; err = 0.
- Write 128 bytes at 0x0FC0 with the macro defined -> AW 0x0FC0 len 7, then AW 0x1000 len 7. With the macro undefined -> a single AW 0x0FC0 len 15.
- Read 1024 bytes with arready = 1, rvalid = 0 -> exactly 4 ARs issued, then arvalid stays 0. After one rlast handshake the 5th AR is presented next cycle.
- Read 64 bytes with rresp = 2'b10 on beat 3 -> err = 1 at done. The next cmd accept clears err to 0.
- cmd_len = 0 -> done one cycle after accept, with no AW/AR/W valid ever asserted.
- rst_n low mid-write after 5 beats -> all valid outputs 0 immediately, asynchronously. After release, cmd_ready = 1 once init_cmptd = 1.
